glyph_row_seq: RTL

GLYPH_ROW_SEQ -- requirements
Module: glyph_row_seq

---
 rtl/glyph_pkg.sv | 16 +
 rtl/glyph_shift8.sv | 44 ++++
 rtl/glyph_row_seq.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/glyph_pkg.sv
// Shared types and constants for the glyph scanline sequencer.
package glyph_pkg;

  localparam int unsigned COLS_DEF   = 80;
  localparam int unsigned CODE_W_DEF = 6;
  localparam int unsigned COL_W      = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    STROBE = 3'd2,
    WAIT   = 3'd3,
    SHIFT  = 3'd4
  } state_e;

endpackage

// File: rtl/glyph_shift8.sv
// 8-bit parallel-load, MSB-first shift register with an accepted-pixel counter.
module glyph_shift8
  import glyph_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       shift_en,
  output logic       msb,
  output logic       last
);

  logic [7:0] sr_q, sr_d;
  logic [2:0] cnt_q, cnt_d;

  // NOTE: every signal written here gets a default first, so no path infers a latch.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load) begin
      sr_d  = load_data;
      cnt_d = 3'd0;
    end else if (shift_en) begin
      sr_d  = {sr_q[6:0], 1'b0};
      cnt_d = cnt_q + 3'd1;
    end
  end

  // NOTE: rst_n is synchronous here: it only takes effect at a rising clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q  <= 8'd0;
      cnt_q <= 3'd0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign msb  = sr_q[7];
  assign last = (cnt_q == 3'd7);

endmodule

// File: rtl/glyph_row_seq.sv
// Renders one scanline: per column fetch the code, strobe the glyph lookup, shift 8 pixels.
// Optional cursor inversion is compiled in with `define GLYPH_CURSOR_EN.
module glyph_row_seq
  import glyph_pkg::*;
#(
  parameter int unsigned COLS   = COLS_DEF,
  parameter int unsigned CODE_W = CODE_W_DEF
) (
  input  logic              s,
  input  logic              rst_n,
  input  logic              line_start,
  input  logic [2:0]        glyph_row,
  output logic              txt_req,
  output logic [COL_W-1:0]  txt_addr,
  input  logic              txt_ack,
  input  logic [CODE_W-1:0] txt_code,
  output logic [CODE_W-1:0] lk_sel,
  output logic [2:0]        lk_row,
  output logic              lk_strobe,
  input  logic [7:0]        lk_data,
  output logic              pix_out,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              line_done,
  output logic              busy
`ifdef GLYPH_CURSOR_EN
  ,
  input  logic              cursor_on,
  input  logic [COL_W-1:0]  cursor_col
`endif
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [2:0]        row_q, row_d;
  logic [CODE_W-1:0] sel_q, sel_d;
  logic              line_done_q, line_done_d;

  logic sh_load, sh_shift, sh_msb, sh_last;
  logic accept;
  logic cur_inv;

`ifdef GLYPH_CURSOR_EN
  logic             cursor_on_q, cursor_on_d;
  logic [COL_W-1:0] cursor_col_q, cursor_col_d;

  always_comb begin
    cursor_on_d  = cursor_on_q;
    cursor_col_d = cursor_col_q;
    if (state_q == IDLE && line_start) begin
      cursor_on_d  = cursor_on;
      cursor_col_d = cursor_col;
    end
  end

  always_ff @(posedge s) begin
    if (!rst_n) begin
      cursor_on_q  <= 1'b0;
      cursor_col_q <= '0;
    end else begin
      cursor_on_q  <= cursor_on_d;
      cursor_col_q <= cursor_col_d;
    end
  end

  assign cur_inv = cursor_on_q && (col_q == cursor_col_q);
`else
  assign cur_inv = 1'b0;
`endif

  assign accept = (state_q == SHIFT) && pix_ready;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    sel_d       = sel_q;
    line_done_d = 1'b0;
    sh_load     = 1'b0;
    sh_shift    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // line_start is only honoured here; pulses mid-line fall through untouched.
        if (line_start) begin
          row_d   = glyph_row;
          col_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (txt_ack) begin
          sel_d   = txt_code;
          state_d = STROBE;
        end
      end
      STROBE: state_d = WAIT;
      WAIT: begin
        sh_load = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (accept) begin
          sh_shift = 1'b1;
          if (sh_last) begin
            if (col_q == LAST_COL) begin
              line_done_d = 1'b1;
              state_d     = IDLE;
            end else begin
              col_d   = col_q + COL_W'(1);
              state_d = FETCH;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge s) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= 3'd0;
      sel_q       <= '0;
      line_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      sel_q       <= sel_d;
      line_done_q <= line_done_d;
    end
  end

  glyph_shift8 u_shift (
    .clk       (s),
    .rst_n     (rst_n),
    .load      (sh_load),
    .load_data (lk_data),
    .shift_en  (sh_shift),
    .msb       (sh_msb),
    .last      (sh_last)
  );

  assign txt_req   = (state_q == FETCH);
  assign txt_addr  = txt_req ? col_q : '0;
  assign lk_sel    = sel_q;
  assign lk_row    = row_q;
  assign lk_strobe = (state_q == STROBE);
  assign pix_valid = (state_q == SHIFT);
  assign pix_out   = pix_valid && (sh_msb ^ cur_inv);
  assign line_done = line_done_q;
  assign busy      = (state_q != IDLE);

endmodule
